// File: rtl/mipi_csi_raw_depacker.sv
`default_nettype none
// mipi_csi_raw_depacker: unpacks CSI-2 RAW10/RAW12/RAW14 payload byte groups into 4-pixel beats.
// Optional macro DEPACKER_MSB_ALIGN_EN left-justifies each pixel in its lane (default right-aligned).
module mipi_csi_raw_depacker #(
   parameter int PIXEL_W   = 16,
   parameter int BUF_BYTES = 12
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   input  logic                   data_valid_i,
   input  logic [31:0]            data_i,
   input  logic [2:0]             packet_type_i,
   input  logic [15:0]            packet_length_i,
   output logic                   pixel_valid_o,
   output logic [4*PIXEL_W-1:0]   pixels_o,
   output logic                   line_end_o,
   output logic                   residual_err_o
);

   typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, SKIP} state_t;

   localparam logic [2:0] TYPE_RAW10 = 3'd3;
   localparam logic [2:0] TYPE_RAW12 = 3'd4;
   localparam logic [2:0] TYPE_RAW14 = 3'd5;
   localparam int         CNT_W      = $clog2(BUF_BYTES + 1);

   state_t           state, state_nx;
   logic             prev_valid;
   logic [2:0]       pkt_type, pkt_type_nx;
   logic [15:0]      remaining, remaining_nx;
   logic             truncated, truncated_nx;
   logic [7:0]       acc     [BUF_BYTES];
   logic [7:0]       acc_nx  [BUF_BYTES];
   logic [7:0]       merged  [BUF_BYTES];
   logic [CNT_W-1:0] acc_cnt, acc_cnt_nx, merged_cnt, left_cnt;

   logic [2:0]       cur_type;
   logic [2:0]       grp;
   logic [2:0]       take;
   logic             accept;
   logic             extract;
   logic             line_end_nx;
   logic             residual_nx;
   logic [13:0]      px [4];
   logic [4*PIXEL_W-1:0] pix_word;

   function automatic logic [2:0] group_bytes(input logic [2:0] t);
      case (t)
         TYPE_RAW10: group_bytes = 3'd5;
         TYPE_RAW12: group_bytes = 3'd6;
         default:    group_bytes = 3'd7;
      endcase
   endfunction

   always_ff @(negedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) state <= IDLE;
      else            state <= state_nx;
   end

   always_comb begin
      state_nx     = state;
      pkt_type_nx  = pkt_type;
      remaining_nx = remaining;
      truncated_nx = truncated;
      take         = 3'd0;
      accept       = 1'b0;
      line_end_nx  = 1'b0;
      residual_nx  = 1'b0;
      cur_type     = (state == IDLE) ? packet_type_i : pkt_type;
      grp          = group_bytes(cur_type);

      case (state)
         IDLE: begin
            if (data_valid_i && !prev_valid) begin
               pkt_type_nx  = packet_type_i;
               truncated_nx = 1'b0;
               if (!(packet_type_i inside {TYPE_RAW10, TYPE_RAW12, TYPE_RAW14}) ||
                   (packet_length_i == 16'd0)) begin
                  state_nx = SKIP;
               end else begin
                  accept       = 1'b1;
                  take         = (packet_length_i > 16'd3) ? 3'd4 : packet_length_i[2:0];
                  remaining_nx = packet_length_i - {13'd0, take};
                  state_nx     = ACTIVE;
               end
            end
         end
         ACTIVE: begin
            if (remaining == 16'd0) begin
               state_nx = DRAIN;
            end else if (!data_valid_i) begin
               state_nx     = DRAIN;
               truncated_nx = 1'b1;
            end else begin
               accept       = 1'b1;
               take         = (remaining > 16'd3) ? 3'd4 : remaining[2:0];
               remaining_nx = remaining - {13'd0, take};
               if (remaining_nx == 16'd0) state_nx = DRAIN;
            end
         end
         DRAIN: begin
            line_end_nx = 1'b1;
            state_nx    = SKIP;
         end
         default: begin
            if (!data_valid_i) state_nx = IDLE;
         end
      endcase

      // Append the accepted bytes behind the held ones, then pop at most one group from the front.
      for (int i = 0; i < BUF_BYTES; i++) begin
         merged[i] = acc[i];
         for (int j = 0; j < 4; j++) begin
            if (accept && (j < int'(take)) && (i == int'(acc_cnt) + j))
               merged[i] = data_i[8*j +: 8];
         end
      end
      merged_cnt = acc_cnt + CNT_W'(take);
      extract    = ((state == ACTIVE) || (state == DRAIN)) && (merged_cnt >= CNT_W'(grp));
      left_cnt   = extract ? (merged_cnt - CNT_W'(grp)) : merged_cnt;

      for (int i = 0; i < BUF_BYTES; i++) begin
         acc_nx[i] = merged[i];
         if (extract)
            acc_nx[i] = ((i + int'(grp)) < BUF_BYTES) ? merged[i + int'(grp)] : 8'h00;
      end
      acc_cnt_nx = left_cnt;

      if (state == DRAIN) begin
         residual_nx = (left_cnt != '0) || truncated;
         acc_cnt_nx  = '0;
         for (int i = 0; i < BUF_BYTES; i++) acc_nx[i] = 8'h00;
      end

      case (pkt_type)
         TYPE_RAW10: begin
            for (int k = 0; k < 4; k++)
               px[k] = {4'b0000, merged[k], merged[4][2*k +: 2]};
         end
         TYPE_RAW12: begin
            px[0] = {2'b00, merged[0], merged[2][3:0]};
            px[1] = {2'b00, merged[1], merged[2][7:4]};
            px[2] = {2'b00, merged[3], merged[5][3:0]};
            px[3] = {2'b00, merged[4], merged[5][7:4]};
         end
         default: begin
            px[0] = {merged[0], merged[4][5:0]};
            px[1] = {merged[1], merged[5][3:0], merged[4][7:6]};
            px[2] = {merged[2], merged[6][1:0], merged[5][7:4]};
            px[3] = {merged[3], merged[6][7:2]};
         end
      endcase

`ifdef DEPACKER_MSB_ALIGN_EN
      for (int k = 0; k < 4; k++) begin
         case (pkt_type)
            TYPE_RAW10: pix_word[k*PIXEL_W +: PIXEL_W] = PIXEL_W'(px[k]) << (PIXEL_W - 10);
            TYPE_RAW12: pix_word[k*PIXEL_W +: PIXEL_W] = PIXEL_W'(px[k]) << (PIXEL_W - 12);
            default:    pix_word[k*PIXEL_W +: PIXEL_W] = PIXEL_W'(px[k]) << (PIXEL_W - 14);
         endcase
      end
`else
      for (int k = 0; k < 4; k++)
         pix_word[k*PIXEL_W +: PIXEL_W] = PIXEL_W'(px[k]);
`endif
   end

   always_ff @(negedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         prev_valid     <= 1'b0;
         pkt_type       <= 3'd0;
         remaining      <= 16'd0;
         truncated      <= 1'b0;
         acc_cnt        <= '0;
         for (int i = 0; i < BUF_BYTES; i++) acc[i] <= 8'h00;
         pixel_valid_o  <= 1'b0;
         pixels_o       <= '0;
         line_end_o     <= 1'b0;
         residual_err_o <= 1'b0;
      end else begin
         prev_valid     <= data_valid_i;
         pkt_type       <= pkt_type_nx;
         remaining      <= remaining_nx;
         truncated      <= truncated_nx;
         acc_cnt        <= acc_cnt_nx;
         for (int i = 0; i < BUF_BYTES; i++) acc[i] <= acc_nx[i];
         pixel_valid_o  <= extract;
         if (extract) pixels_o <= pix_word;
         line_end_o     <= line_end_nx;
         residual_err_o <= residual_nx;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mipi_csi_raw_depacker.sv
`default_nettype none
// tb_mipi_csi_raw_depacker: directed packets with a scoreboard of hand-computed beats and line ends.
module tb_mipi_csi_raw_depacker;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        data_valid = 1'b0;
   logic [31:0] data = 32'd0;
   logic [2:0]  ptype = 3'd0;
   logic [15:0] plen = 16'd0;
   logic        pixel_valid;
   logic [63:0] pixels;
   logic        line_end;
   logic        residual_err;

   int n_total = 0;
   int n_bad   = 0;

   logic [63:0] exp_pix [$];
   logic        exp_res [$];
   logic [31:0] words   [$];

   mipi_csi_raw_depacker #(.PIXEL_W(16), .BUF_BYTES(12)) dut (
      .clk_i           (clk),
      .reset_n_i       (reset_n),
      .data_valid_i    (data_valid),
      .data_i          (data),
      .packet_type_i   (ptype),
      .packet_length_i (plen),
      .pixel_valid_o   (pixel_valid),
      .pixels_o        (pixels),
      .line_end_o      (line_end),
      .residual_err_o  (residual_err)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] beat(input logic [15:0] p0, input logic [15:0] p1,
                                        input logic [15:0] p2, input logic [15:0] p3,
                                        input int bits);
      int sh;
`ifdef DEPACKER_MSB_ALIGN_EN
      sh = 16 - bits;
`else
      sh = 0;
`endif
      return {p3 << sh, p2 << sh, p1 << sh, p0 << sh};
   endfunction

   task automatic send_packet(input logic [2:0] t, input logic [15:0] len);
      for (int i = 0; i < words.size(); i++) begin
         @(posedge clk); #1;
         data_valid = 1'b1;
         data       = words[i];
         ptype      = t;
         plen       = len;
      end
      @(posedge clk); #1;
      data_valid = 1'b0;
      data       = 32'd0;
      repeat (6) @(posedge clk);
   endtask

   // Monitor: outputs change on the falling edge, so they are stable at the rising edge.
   initial begin
      logic [63:0] e;
      logic        r;
      forever begin
         @(posedge clk);
         if (pixel_valid) begin
            n_total++;
            if (exp_pix.size() == 0) begin
               n_bad++;
               $display("FAIL beat_unexpected got=%h required=none", pixels);
            end else begin
               e = exp_pix.pop_front();
               if (pixels !== e) begin
                  n_bad++;
                  $display("FAIL beat_pixels got=%h required=%h", pixels, e);
               end
            end
         end
         if (line_end) begin
            n_total++;
            if (exp_res.size() == 0) begin
               n_bad++;
               $display("FAIL line_end_unexpected got=1 required=0");
            end else begin
               r = exp_res.pop_front();
               if (residual_err !== r) begin
                  n_bad++;
                  $display("FAIL residual_err got=%b required=%b", residual_err, r);
               end
            end
         end else if (residual_err) begin
            n_total++;
            n_bad++;
            $display("FAIL residual_without_line_end got=1 required=0");
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      n_total++;
      if ({pixel_valid, pixels, line_end, residual_err} !== 67'd0) begin
         n_bad++;
         $display("FAIL reset_outputs got=%h required=0", {pixel_valid, pixels, line_end, residual_err});
      end
      reset_n = 1'b1;
      repeat (3) @(posedge clk);

      // RAW10 length 10 plus a trailing CRC word
      words = '{32'h04030201, 32'h0302FFE4, 32'hAAAA5510, 32'hDEADBEEF};
      exp_pix.push_back(beat(16'h004, 16'h009, 16'h00E, 16'h013, 10));
      exp_pix.push_back(beat(16'h3FD, 16'h009, 16'h00D, 16'h041, 10));
      exp_res.push_back(1'b0);
      send_packet(3'd3, 16'd10);

      // RAW12 length 12
      words = '{32'h1221CDAB, 32'h9A785634, 32'h13F0DEBC};
      exp_pix.push_back(beat(16'hAB1, 16'hCD2, 16'h126, 16'h345, 12));
      exp_pix.push_back(beat(16'h78C, 16'h9AB, 16'hDE3, 16'hF01, 12));
      exp_res.push_back(1'b0);
      send_packet(3'd4, 16'd12);

      // RAW14 length 14, all ones
      words = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
      exp_pix.push_back(beat(16'h3FFF, 16'h3FFF, 16'h3FFF, 16'h3FFF, 14));
      exp_pix.push_back(beat(16'h3FFF, 16'h3FFF, 16'h3FFF, 16'h3FFF, 14));
      exp_res.push_back(1'b0);
      send_packet(3'd5, 16'd14);

      // RAW10 length 20 truncated after two words
      words = '{32'h04030201, 32'h0302FFE4};
      exp_pix.push_back(beat(16'h004, 16'h009, 16'h00E, 16'h013, 10));
      exp_res.push_back(1'b1);
      send_packet(3'd3, 16'd20);

      // Unsupported type: nothing expected
      words = '{32'h11223344, 32'h55667788};
      send_packet(3'd2, 16'd8);

      // RAW10 length 5 right after the skipped packet
      words = '{32'h04030201, 32'h000000E4};
      exp_pix.push_back(beat(16'h004, 16'h009, 16'h00E, 16'h013, 10));
      exp_res.push_back(1'b0);
      send_packet(3'd3, 16'd5);

      // Reset in the middle of a RAW12 packet, while a beat is being presented
      exp_pix.push_back(beat(16'hAB1, 16'hCD2, 16'h126, 16'h345, 12));
      @(posedge clk); #1;
      data_valid = 1'b1; data = 32'h1221CDAB; ptype = 3'd4; plen = 16'd12;
      @(posedge clk); #1;
      data = 32'h9A785634;
      @(posedge clk); #1;
      reset_n    = 1'b0;
      data_valid = 1'b0;
      data       = 32'd0;
      #1;
      n_total++;
      if ({pixel_valid, pixels, line_end, residual_err} !== 67'd0) begin
         n_bad++;
         $display("FAIL midreset_outputs got=%h required=0", {pixel_valid, pixels, line_end, residual_err});
      end
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (3) @(posedge clk);

      words = '{32'h1221CDAB, 32'h9A785634, 32'h13F0DEBC};
      exp_pix.push_back(beat(16'hAB1, 16'hCD2, 16'h126, 16'h345, 12));
      exp_pix.push_back(beat(16'h78C, 16'h9AB, 16'hDE3, 16'hF01, 12));
      exp_res.push_back(1'b0);
      send_packet(3'd4, 16'd12);

      repeat (10) @(posedge clk);
      #1;
      n_total++;
      if (exp_pix.size() != 0) begin
         n_bad++;
         $display("FAIL beats_missing got=%0d required=0", exp_pix.size());
      end
      n_total++;
      if (exp_res.size() != 0) begin
         n_bad++;
         $display("FAIL line_ends_missing got=%0d required=0", exp_res.size());
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
